// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C slave register port.
package i2c_pkg;

    typedef enum logic [3:0] {
        StIdle,
        StAddr,
        StAddrAck,
        StPtr,
        StPtrAck,
        StWdata,
        StWdataAck,
        StRdata,
        StRdataAck
    } i2c_state_e;

    localparam logic I2C_ACK  = 1'b0;
    localparam logic I2C_NACK = 1'b1;

    localparam logic [6:0] I2C_DEFAULT_DEV_ADDR = 7'h53;

endpackage

// File: rtl/i2c_line_filter.sv
// Two-flop synchroniser, FILTER_LEN-deep stability filter and edge pulses for one I2C line.
module i2c_line_filter #(
    parameter int unsigned FILTER_LEN = 3
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_line,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic [1:0]            r_sync;
    logic [FILTER_LEN-1:0] r_hist;
    logic                  r_level;
    logic                  r_rise;
    logic                  r_fall;
    logic                  w_level_next;

    // Level only moves once the whole history window agrees.
    always_comb begin
        w_level_next = r_level;
        if (&r_hist) begin
            w_level_next = 1'b1;
        end else if (~|r_hist) begin
            w_level_next = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_sync  <= '1;
            r_hist  <= '1;
            r_level <= 1'b1;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_sync  <= {r_sync[0], i_line};
            r_hist  <= (r_hist << 1) | FILTER_LEN'(r_sync[1]);
            r_level <= w_level_next;
            r_rise  <= w_level_next & ~r_level;
            r_fall  <= ~w_level_next & r_level;
        end
    end

    assign o_level = r_level;
    assign o_rise  = r_rise;
    assign o_fall  = r_fall;

endmodule

// File: rtl/i2c_slave_regport.sv
// Oversampled I2C slave: address match, register pointer with auto-increment,
// and a strobe-based register-file port.
module i2c_slave_regport
    import i2c_pkg::*;
#(
    parameter logic [6:0]  DEV_ADDR   = I2C_DEFAULT_DEV_ADDR,
    parameter int unsigned ADDR_W     = 6,
    parameter int unsigned FILTER_LEN = 3
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_scl,
    input  logic              i_sda_in,
    output logic              o_sda_oe,
    output logic [ADDR_W-1:0] o_reg_addr,
    output logic [7:0]        o_reg_wdata,
    output logic              o_reg_we,
    output logic              o_reg_re,
    input  logic [7:0]        i_reg_rdata,
    output logic              o_busy
);

    logic w_scl, w_scl_rise, w_scl_fall;
    logic w_sda, w_sda_rise, w_sda_fall;

    i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_scl_filter (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_line  (i_scl),
        .o_level (w_scl),
        .o_rise  (w_scl_rise),
        .o_fall  (w_scl_fall)
    );

    i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_sda_filter (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_line  (i_sda_in),
        .o_level (w_sda),
        .o_rise  (w_sda_rise),
        .o_fall  (w_sda_fall)
    );

    i2c_state_e        r_state, w_state_d;
    logic [3:0]        r_bit_cnt, w_bit_cnt_d;
    logic [6:0]        r_shift, w_shift_d;
    logic [6:0]        r_tx, w_tx_d;
    logic              r_sda_oe, w_sda_oe_d;
    logic              r_busy, w_busy_d;
    logic [ADDR_W-1:0] r_reg_addr, w_reg_addr_d;
    logic [7:0]        r_reg_wdata, w_reg_wdata_d;
    logic              r_we, w_we_d;
    logic              r_re, w_re_d;
    logic [1:0]        r_rd_wait, w_rd_wait_d;

    logic       w_start;
    logic       w_stop;
    logic [7:0] w_byte;

    assign w_start = w_sda_fall & w_scl;
    assign w_stop  = w_sda_rise & w_scl;
    assign w_byte  = {r_shift, w_sda};

    always_comb begin
        w_state_d     = r_state;
        w_bit_cnt_d   = r_bit_cnt;
        w_shift_d     = r_shift;
        w_tx_d        = r_tx;
        w_sda_oe_d    = r_sda_oe;
        w_busy_d      = r_busy;
        w_reg_addr_d  = r_reg_addr;
        w_reg_wdata_d = r_reg_wdata;
        w_we_d        = 1'b0;
        w_re_d        = 1'b0;
        // r_rd_wait[1] marks the clk on which reg_rdata is valid
        w_rd_wait_d   = {r_rd_wait[0], 1'b0};

        if (w_stop) begin
            w_state_d   = StIdle;
            w_sda_oe_d  = 1'b0;
            w_busy_d    = 1'b0;
            w_bit_cnt_d = '0;
            w_rd_wait_d = '0;
        end else if (w_start) begin
            w_state_d   = StAddr;
            w_sda_oe_d  = 1'b0;
            w_bit_cnt_d = '0;
            w_rd_wait_d = '0;
        end else begin
            unique case (r_state)
                StIdle: ;
                StAddr, StPtr, StWdata: begin
                    if (w_scl_rise && r_bit_cnt < 4'd8) begin
                        w_shift_d   = w_byte[6:0];
                        w_bit_cnt_d = r_bit_cnt + 4'd1;
                        if (r_bit_cnt == 4'd7) begin
                            if (r_state == StAddr) begin
                                if (w_byte[7:1] == DEV_ADDR) begin
                                    w_busy_d = 1'b1;
                                end else begin
                                    w_state_d = StIdle;
                                    w_busy_d  = 1'b0;
                                end
                            end else if (r_state == StPtr) begin
                                w_reg_addr_d = w_byte[ADDR_W-1:0];
                            end else begin
                                w_reg_wdata_d = w_byte;
                                w_we_d        = 1'b1;
                            end
                        end
                    end else if (w_scl_fall && r_bit_cnt == 4'd8) begin
                        w_sda_oe_d  = ~I2C_ACK;
                        w_bit_cnt_d = '0;
                        if (r_state == StAddr) begin
                            w_state_d = StAddrAck;
                        end else if (r_state == StPtr) begin
                            w_state_d = StPtrAck;
                        end else begin
                            w_state_d = StWdataAck;
                        end
                    end
                end
                StAddrAck: begin
                    if (w_scl_fall) begin
                        w_sda_oe_d = 1'b0;
                        if (r_shift[0]) begin
                            w_state_d   = StRdata;
                            w_re_d      = 1'b1;
                            w_rd_wait_d = 2'b01;
                        end else begin
                            w_state_d = StPtr;
                        end
                    end
                end
                StPtrAck: begin
                    if (w_scl_fall) begin
                        w_sda_oe_d = 1'b0;
                        w_state_d  = StWdata;
                    end
                end
                StWdataAck: begin
                    if (w_scl_fall) begin
                        w_sda_oe_d   = 1'b0;
                        w_reg_addr_d = r_reg_addr + ADDR_W'(1);
                        w_state_d    = StWdata;
                    end
                end
                StRdata: begin
                    if (r_rd_wait[1]) begin
                        w_tx_d      = i_reg_rdata[6:0];
                        w_sda_oe_d  = ~i_reg_rdata[7];
                        w_bit_cnt_d = '0;
                    end else if (w_scl_fall) begin
                        if (r_bit_cnt == 4'd7) begin
                            w_sda_oe_d  = 1'b0;
                            w_bit_cnt_d = '0;
                            w_state_d   = StRdataAck;
                        end else begin
                            w_sda_oe_d  = ~r_tx[6];
                            w_tx_d      = {r_tx[5:0], 1'b0};
                            w_bit_cnt_d = r_bit_cnt + 4'd1;
                        end
                    end
                end
                StRdataAck: begin
                    // bit_cnt=1 remembers a master ACK until the next scl_fall
                    if (w_scl_rise) begin
                        if (w_sda == I2C_ACK) begin
                            w_reg_addr_d = r_reg_addr + ADDR_W'(1);
                            w_bit_cnt_d  = 4'd1;
                        end else begin
                            w_state_d = StIdle;
                            w_busy_d  = 1'b0;
                        end
                    end else if (w_scl_fall && r_bit_cnt == 4'd1) begin
                        w_re_d      = 1'b1;
                        w_rd_wait_d = 2'b01;
                        w_bit_cnt_d = '0;
                        w_state_d   = StRdata;
                    end
                end
                default: w_state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state     <= StIdle;
            r_bit_cnt   <= '0;
            r_shift     <= '0;
            r_tx        <= '0;
            r_sda_oe    <= 1'b0;
            r_busy      <= 1'b0;
            r_reg_addr  <= '0;
            r_reg_wdata <= '0;
            r_we        <= 1'b0;
            r_re        <= 1'b0;
            r_rd_wait   <= '0;
        end else begin
            r_state     <= w_state_d;
            r_bit_cnt   <= w_bit_cnt_d;
            r_shift     <= w_shift_d;
            r_tx        <= w_tx_d;
            r_sda_oe    <= w_sda_oe_d;
            r_busy      <= w_busy_d;
            r_reg_addr  <= w_reg_addr_d;
            r_reg_wdata <= w_reg_wdata_d;
            r_we        <= w_we_d;
            r_re        <= w_re_d;
            r_rd_wait   <= w_rd_wait_d;
        end
    end

    assign o_sda_oe    = r_sda_oe;
    assign o_reg_addr  = r_reg_addr;
    assign o_reg_wdata = r_reg_wdata;
    assign o_reg_we    = r_we;
    assign o_reg_re    = r_re;
    assign o_busy      = r_busy;

endmodule

// File: doc/i2c_slave_regport.md
Name: i2c_slave_regport

Overview:
- Parametrised, fully synchronous I2C slave front-end for behavioural sensor models, starting with the ADXL345.
- Oversamples SCL/SDA on a single system clock; no logic is clocked on bus edges.
- Decodes START/STOP, matches a configurable 7-bit device address, ACKs, and manages a register pointer with auto-increment.
- Exposes a simple register-file port (write strobe, read strobe, data) to the model's register bank.

Parameters:
- DEV_ADDR, 7'h53, 7-bit slave address to match.
- ADDR_W, 6, register pointer width; register space is 2**ADDR_W bytes.
- FILTER_LEN, 3, consecutive equal samples needed before a synchronised SCL/SDA level is accepted.

Ports:
- clk  input  1  system clock, at least 8x the SCL rate.
- rst_n  input  1  synchronous active-low reset.
- scl  input  1  I2C clock, asynchronous.
- sda_in  input  1  I2C data as sampled from the pad, asynchronous.
- sda_oe  output  1  1 = pull SDA low (open-drain); 0 = release.
- reg_addr  output  ADDR_W  current register pointer.
- reg_wdata  output  8  byte written by the master.
- reg_we  output  1  one-clk write strobe, qualified by reg_addr/reg_wdata.
- reg_re  output  1  one-clk read request for reg_addr.
- reg_rdata  input  8  read data; valid on the clk after reg_re.
- busy  output  1  high from address match until STOP or NACK.

Behaviour:
- Reset: clk is the only clock; reset is synchronous and active-low. While rst_n=0 at a clk edge: sda_oe=0, reg_we=0, reg_re=0, busy=0, reg_addr=0, reg_wdata=0, FSM=IDLE, synchronisers and filters preset to 1. Reset mid-transaction releases SDA on the next clk edge.
- Input conditioning: 2-flop synchroniser, then a FILTER_LEN-deep stable filter. The filtered levels are scl_f/sda_f.
  - scl_rise/scl_fall: one-clk pulses on scl_f edges.
  - START: sda_f falls while scl_f=1. STOP: sda_f rises while scl_f=1.
- Sampling and driving: bits are sampled on scl_rise, MSB first. sda_oe changes only on scl_fall, except for the reset and STOP release rules.
- FSM states: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK.
- START (including repeated START) in any state -> ADDR, bit counter cleared, sda_oe=0.
- STOP in any state -> IDLE, sda_oe=0, busy=0. The pointer is retained.
- ADDR: after 8 bits, compare bits[7:1] to DEV_ADDR.
  - Mismatch -> IDLE, no ACK.
  - Match: busy=1. On the next scl_fall, sda_oe=1 -> ADDR_ACK.
- ADDR_ACK: on the following scl_fall, sda_oe=0.
  - R/W=0 -> PTR.
  - R/W=1 -> RDATA; reg_re pulses on that same scl_fall.
- PTR: after 8 bits, reg_addr <= byte[ADDR_W-1:0]; upper bits are ignored. ACK as above -> PTR_ACK -> WDATA.
- WDATA: after 8 bits, reg_wdata <= byte and reg_we pulses for exactly one clk. ACK -> WDATA_ACK. On release, reg_addr <= reg_addr+1 (wraps mod 2**ADDR_W) -> WDATA.
- RDATA:
  - reg_rdata is captured one clk after reg_re into the TX shifter.
  - bit7 is driven immediately (sda_oe = ~bit); subsequent bits go out on each scl_fall.
  - After the 8th bit's scl_fall, sda_oe=0 -> RDATA_ACK.
- RDATA_ACK: master ACK/NACK is sampled on scl_rise.
  - ACK (0): reg_addr increments (wraps); reg_re pulses on the next scl_fall -> RDATA.
  - NACK (1): -> IDLE, busy=0.
- Simultaneous events: STOP/START take priority over any bit event in the same clk. reg_we and reg_re never assert in the same clk.
- Glitches shorter than FILTER_LEN clks produce no edge.

Decomposition:
- Package i2c_pkg: FSM state enum, I2C_ACK=1'b0 / I2C_NACK=1'b1 constants, default DEV_ADDR.
- Sub-module i2c_line_filter (synchroniser + stable filter + edge pulses), instantiated once each for SCL and SDA.

Test Plan:
- Write: START, 0xA6 (0x53,W), 0x2D, 0x08, STOP -> ACK on all 3 bytes; reg_we pulse with reg_addr=0x2D, reg_wdata=0x08; reg_addr=0x2E after STOP.
- Burst read: START, 0xA6, 0x32, Sr, 0xA7, read 2 bytes with reg_rdata=0x11 then 0x22, master ACK then NACK -> SDA shows 0x11, 0x22; reg_re pulses at 0x32 and 0x33; busy=0 after NACK.
- Address mismatch: START, 0x3A -> no ACK (sda_oe stays 0), no strobes, busy stays 0.
- Wrap: pointer 0x3F, write 2 bytes -> reg_we at 0x3F then 0x00.
- Glitch/reset: 1-clk low pulse on SDA while SCL high -> no START detected. Assert rst_n=0 during an ACK -> sda_oe=0 on the next clk, FSM in IDLE.
